// File: rtl/level_sequencer_pkg.sv
// level_sequencer_pkg: shared game-flow state type and level/lives constants
package level_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, LEVEL_DONE, WON, LOST} state_t;
    localparam logic [1:0] LEVEL_ONE = 2'b00;
    localparam logic [1:0] LEVEL_TWO = 2'b01;
    localparam int DEFAULT_START_LIVES = 3;
endpackage

// File: rtl/level_sequencer_frame_pause_counter.sv
// frame_pause_counter: counts startOfFrame ticks and flags the last tick of the pause
module frame_pause_counter #(
    parameter int PAUSE_FRAMES = 120
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic startOfFrame,
    output logic done
);
    localparam int W = $clog2(PAUSE_FRAMES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (reset || clear) ? '0 : cnt + W'(startOfFrame);
    assign done = startOfFrame && (cnt == W'(PAUSE_FRAMES - 1));
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM sequencing levels, lives, pauses and end screens
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS   = 2,
    parameter int START_LIVES  = DEFAULT_START_LIVES,
    parameter int PAUSE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startBtn,
    input  logic       startOfFrame,
    input  logic       flagHit,
    input  logic       playerDied,
    output logic [1:0] levelCode,
    output logic       levelLoad,
    output logic       scoreClear,
    output logic       playEnable,
    output logic [1:0] livesLeft,
    output logic       gameWon,
    output logic       gameOver
);
    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [1:0] FULL_LIVES = 2'(START_LIVES);
    state_t state_q, state_d;
    logic [1:0] level_q, level_d, lives_q, lives_d;
    logic start_d, start_rise, pause_done;
    assign start_rise = startBtn & ~start_d;
    frame_pause_counter #(.PAUSE_FRAMES(PAUSE_FRAMES)) u_pause (
        .clk          (clk),
        .reset        (reset),
        .clear        (state_q != LEVEL_DONE),
        .startOfFrame (startOfFrame),
        .done         (pause_done)
    );
    always_ff @(posedge clk) begin
        start_d <= startBtn;
        if (reset) begin
            state_q <= IDLE;
            level_q <= LEVEL_ONE;
            lives_q <= FULL_LIVES;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
        end
    end
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        unique case (state_q)
            IDLE, WON, LOST: if (start_rise) begin
                state_d = LOAD;
                level_d = LEVEL_ONE;
                lives_d = FULL_LIVES;
            end
            LOAD: state_d = PLAY;
            PLAY: if (flagHit) state_d = LEVEL_DONE;
                else if (playerDied) begin
                    state_d = (lives_q == 2'd1) ? LOST : LOAD;
                    lives_d = lives_q - 2'd1;
                end
            LEVEL_DONE: if (pause_done) begin
                state_d = (level_q == LAST_LEVEL) ? WON : LOAD;
                level_d = (level_q == LAST_LEVEL) ? level_q : level_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign levelCode  = level_q;
    assign livesLeft  = lives_q;
    assign levelLoad  = (state_q == LOAD) && !reset;
    assign scoreClear = (state_q == LOAD) && !reset;
    assign playEnable = state_q == PLAY;
    assign gameWon    = state_q == WON;
    assign gameOver   = state_q == LOST;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed scenario checks of level_sequencer with short pause
module tb_level_sequencer;
    logic clk = 0, reset = 1, startBtn = 0, startOfFrame = 0, flagHit = 0, playerDied = 0;
    logic [1:0] levelCode, livesLeft;
    logic levelLoad, scoreClear, playEnable, gameWon, gameOver;
    logic [8:0] obs, exp;
    int vectors = 0, errors = 0;
    level_sequencer #(.NUM_LEVELS(2), .START_LIVES(3), .PAUSE_FRAMES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .startBtn     (startBtn),
        .startOfFrame (startOfFrame),
        .flagHit      (flagHit),
        .playerDied   (playerDied),
        .levelCode    (levelCode),
        .levelLoad    (levelLoad),
        .scoreClear   (scoreClear),
        .playEnable   (playEnable),
        .livesLeft    (livesLeft),
        .gameWon      (gameWon),
        .gameOver     (gameOver)
    );
    always #5 clk = ~clk;
    // bundle: level, lives, load, clear, play, won, over
    assign obs = {levelCode, livesLeft, levelLoad, scoreClear, playEnable, gameWon, gameOver};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        exp = {2'd0, 2'd3, 5'b00000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state got %b exp %b", obs, exp); end
        reset = 0; flagHit = 1; playerDied = 1;
        tick();
        flagHit = 0; playerDied = 0;
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL idle_ignores_events got %b exp %b", obs, exp); end
    endtask

    task automatic test_start();
        startBtn = 1;
        tick();
        exp = {2'd0, 2'd3, 5'b11000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL start_load got %b exp %b", obs, exp); end
        tick();
        exp = {2'd0, 2'd3, 5'b00100}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL start_play got %b exp %b", obs, exp); end
        tick(); tick(); tick();
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL start_held_single got %b exp %b", obs, exp); end
        startBtn = 0;
        tick();
    endtask

    task automatic test_level_advance(input logic [1:0] lvl, input logic last);
        flagHit = 1;
        tick();
        flagHit = 0;
        exp = {lvl, 2'd3, 5'b00000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL flag_pause got %b exp %b", obs, exp); end
        for (int i = 0; i < 4; i++) begin
            startOfFrame = 1;
            tick();
            startOfFrame = 0;
            if (i < 3) begin
                vectors++;
                if (obs !== exp) begin errors++; $display("FAIL pause_frame%0d got %b exp %b", i, obs, exp); end
                tick();
            end
        end
        exp = last ? {lvl, 2'd3, 5'b00010} : {lvl + 2'd1, 2'd3, 5'b11000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL pause_end got %b exp %b", obs, exp); end
        tick();
        exp = last ? {lvl, 2'd3, 5'b00010} : {lvl + 2'd1, 2'd3, 5'b00100}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL after_pause got %b exp %b", obs, exp); end
    endtask

    task automatic test_restart(input logic [1:0] lives_now, input logic [4:0] end_flags);
        exp = {2'd0, lives_now, end_flags};
        startBtn = 1;
        tick();
        startBtn = 0;
        exp = {2'd0, 2'd3, 5'b11000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL restart_load got %b exp %b", obs, exp); end
        tick();
        exp = {2'd0, 2'd3, 5'b00100}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL restart_play got %b exp %b", obs, exp); end
    endtask

    task automatic test_death(input logic [1:0] after);
        playerDied = 1;
        tick();
        playerDied = 0;
        exp = (after == 0) ? {2'd0, 2'd0, 5'b00001} : {2'd0, after, 5'b11000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL death_to_%0d got %b exp %b", after, obs, exp); end
        tick();
        exp = (after == 0) ? {2'd0, 2'd0, 5'b00001} : {2'd0, after, 5'b00100}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL death_settle_%0d got %b exp %b", after, obs, exp); end
    endtask

    task automatic test_simultaneous();
        flagHit = 1; playerDied = 1;
        tick();
        flagHit = 0; playerDied = 0;
        exp = {2'd0, 2'd1, 5'b00000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL flag_beats_death got %b exp %b", obs, exp); end
        flagHit = 1; playerDied = 1; startBtn = 1;
        tick();
        flagHit = 0; playerDied = 0; startBtn = 0;
        tick();
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL pause_ignores_events got %b exp %b", obs, exp); end
    endtask

    task automatic test_reset_mid_pause();
        for (int i = 0; i < 2; i++) begin
            startOfFrame = 1; tick(); startOfFrame = 0; tick();
        end
        reset = 1; startBtn = 1;
        tick();
        reset = 0;
        exp = {2'd0, 2'd3, 5'b00000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_pause got %b exp %b", obs, exp); end
        tick(); tick();
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL held_btn_no_load got %b exp %b", obs, exp); end
        startBtn = 0;
        tick();
        startBtn = 1;
        tick();
        startBtn = 0;
        exp = {2'd0, 2'd3, 5'b11000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL repress_load got %b exp %b", obs, exp); end
        reset = 1;
        #1;
        exp = {2'd0, 2'd3, 5'b00000}; vectors++;
        if (obs !== exp) begin errors++; $display("FAIL no_pulse_in_reset got %b exp %b", obs, exp); end
        tick();
        reset = 0;
        tick();
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_load got %b exp %b", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_advance(2'd0, 1'b0);
        test_level_advance(2'd1, 1'b1);
        test_restart(2'd3, 5'b00010);
        test_death(2'd2);
        test_death(2'd1);
        test_death(2'd0);
        test_restart(2'd0, 5'b00001);
        test_death(2'd2);
        test_death(2'd1);
        test_simultaneous();
        test_reset_mid_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
